hazard_ctrl: RTL and testbench

Pipeline sequencer for the 5-stage core. It drives enable and flush for the PC and for the IF/ID, ID/EX, EX/MEM and MEM/WB register banks. The ID/EX bank clears on flush=1 exactly as it does on rst. It resolves load-use hazards, taken branches, multi-cycle EX operations and data-memory wait states. It also keeps saturating stall and flush counters.

---
 rtl/pipe_ctrl_pkg.sv | 37 +++
 rtl/hazard_detect.sv | 25 ++
 rtl/hazard_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: FSM encoding, register
// address width and the canned control-word patterns driven to the banks.
package pipe_ctrl_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_EX_WAIT  = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_HALT     = 2'd3
  } state_e;

  typedef struct packed {
    logic pc_en;
    logic pc_sel_branch;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
    logic memwb_flush;
    logic ex_start;
  } ctrl_t;

  // Field order: pc_en sel | ifid idex exmem memwb enables | same flushes | ex_start
  localparam ctrl_t CTRL_OFF    = ctrl_t'(11'b00_0000_0000_0);
  localparam ctrl_t CTRL_RUN    = ctrl_t'(11'b10_1111_0000_0);
  localparam ctrl_t CTRL_BRANCH = ctrl_t'(11'b11_1111_1110_0);
  localparam ctrl_t CTRL_MULTI  = ctrl_t'(11'b00_0011_0010_1);
  localparam ctrl_t CTRL_EX_FRZ = ctrl_t'(11'b00_0011_0010_0);
  localparam ctrl_t CTRL_MEM    = ctrl_t'(11'b00_0001_0001_0);
  localparam ctrl_t CTRL_LOAD   = ctrl_t'(11'b00_0111_0100_0);

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the ID instruction's sources and the
// destination of a load currently in EX. Purely combinational.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  output logic                  load_use
);

  logic rs1_hit;
  logic rs2_hit;

  always_comb begin
    rs1_hit  = id_uses_rs1 && (id_rs1 == ex_rd);
    rs2_hit  = id_uses_rs2 && (id_rs2 == ex_rd);
    // x0 is hardwired to zero, so a load targeting it never creates a hazard.
    load_use = ex_mem_read && (ex_rd != '0) && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: drives PC and bank enables/flushes, sequences multi-cycle
// EX operations and data-memory waits, and keeps saturating stall/flush counts.
module hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] idReadDir1,
  input  logic [REG_ADDR_W-1:0] idReadDir2,
  input  logic                  idUsesRS1,
  input  logic                  idUsesRS2,
  input  logic [REG_ADDR_W-1:0] exWriteDir,
  input  logic                  exMemRead,
  input  logic                  exMulti,
  input  logic                  exDone,
  input  logic                  memBranchTaken,
  input  logic                  memAccess,
  input  logic                  dmemReady,
  output logic                  pcEn,
  output logic                  pcSelBranch,
  output logic                  ifidEn,
  output logic                  idexEn,
  output logic                  exmemEn,
  output logic                  memwbEn,
  output logic                  ifidFlush,
  output logic                  idexFlush,
  output logic                  exmemFlush,
  output logic                  memwbFlush,
  output logic                  exStart,
  output logic                  memTimeout,
  output logic [CNT_W-1:0]      stallCount,
  output logic [CNT_W-1:0]      flushCount
);

  localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_e            state_q,     state_d;
  state_e            resume_q,    resume_d;
  state_e            eff_state;
  logic [WAIT_W-1:0] wait_cnt_q,  wait_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic              timeout_q,   timeout_d;
  logic              load_use;
  logic              mem_wait;
  logic              start_mem_wait;
  logic              flush_evt;
  ctrl_t             ctrl;

  hazard_detect u_hazard_detect (
    .id_rs1      (idReadDir1),
    .id_rs2      (idReadDir2),
    .id_uses_rs1 (idUsesRS1),
    .id_uses_rs2 (idUsesRS2),
    .ex_rd       (exWriteDir),
    .ex_mem_read (exMemRead),
    .load_use    (load_use)
  );

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d        = state_q;
    resume_d       = resume_q;
    wait_cnt_d     = wait_cnt_q;
    timeout_d      = timeout_q;
    ctrl           = CTRL_RUN;
    start_mem_wait = 1'b0;
    flush_evt      = 1'b0;
    mem_wait       = memAccess && !dmemReady;

    // A finished memory wait behaves, that same cycle, like the state it interrupted.
    eff_state = state_q;
    if (state_q == ST_MEM_WAIT && dmemReady) begin
      eff_state = resume_q;
    end

    case (eff_state)
      ST_RUN: begin
        state_d = ST_RUN;
        if (mem_wait) begin
          ctrl           = CTRL_MEM;
          resume_d       = ST_RUN;
          start_mem_wait = 1'b1;
        end else if (memBranchTaken) begin
          ctrl      = CTRL_BRANCH;
          flush_evt = 1'b1;
        end else if (exMulti) begin
          ctrl    = CTRL_MULTI;
          state_d = ST_EX_WAIT;
        end else if (load_use) begin
          ctrl = CTRL_LOAD;
        end
      end
      ST_EX_WAIT: begin
        if (mem_wait) begin
          // The EX unit holds its result; come back here to capture it.
          ctrl           = CTRL_MEM;
          resume_d       = ST_EX_WAIT;
          start_mem_wait = 1'b1;
        end else if (exDone) begin
          ctrl    = CTRL_RUN;
          state_d = ST_RUN;
        end else begin
          ctrl    = CTRL_EX_FRZ;
          state_d = ST_EX_WAIT;
        end
      end
      ST_MEM_WAIT: begin
        ctrl       = CTRL_MEM;
        wait_cnt_d = wait_cnt_q + 1'b1;
        if (wait_cnt_q >= WAIT_LAST) begin
          timeout_d = 1'b1;
          state_d   = ST_HALT;
        end
      end
      ST_HALT: ctrl = CTRL_OFF;
      default: ctrl = CTRL_OFF;
    endcase

    if (start_mem_wait) begin
      wait_cnt_d = WAIT_W'(1);
      if (WAIT_LAST == '0) begin
        timeout_d = 1'b1;
        state_d   = ST_HALT;
      end else begin
        state_d = ST_MEM_WAIT;
      end
    end

    if (rst) begin
      ctrl = CTRL_OFF;
    end

    stall_cnt_d = stall_cnt_q;
    if (!ctrl.pc_en && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    flush_cnt_d = flush_cnt_q;
    if (flush_evt && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      resume_q    <= ST_RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      resume_q    <= resume_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign pcEn        = ctrl.pc_en;
  assign pcSelBranch = ctrl.pc_sel_branch;
  assign ifidEn      = ctrl.ifid_en;
  assign idexEn      = ctrl.idex_en;
  assign exmemEn     = ctrl.exmem_en;
  assign memwbEn     = ctrl.memwb_en;
  assign ifidFlush   = ctrl.ifid_flush;
  assign idexFlush   = ctrl.idex_flush;
  assign exmemFlush  = ctrl.exmem_flush;
  assign memwbFlush  = ctrl.memwb_flush;
  assign exStart     = ctrl.ex_start;
  assign memTimeout  = timeout_q;
  assign stallCount  = stall_cnt_q;
  assign flushCount  = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: expected control words and counter values
// are queued at drive time and compared against the DUT at the falling edge.
module tb_hazard_ctrl;

  localparam logic [10:0] P_OFF  = 11'b00_0000_0000_0;
  localparam logic [10:0] P_RUN  = 11'b10_1111_0000_0;
  localparam logic [10:0] P_BR   = 11'b11_1111_1110_0;
  localparam logic [10:0] P_MC   = 11'b00_0011_0010_1;
  localparam logic [10:0] P_FRZ  = 11'b00_0011_0010_0;
  localparam logic [10:0] P_MW   = 11'b00_0001_0001_0;
  localparam logic [10:0] P_LU   = 11'b00_0111_0100_0;

  typedef struct {
    logic [10:0] outs;
    logic [15:0] stall;
    logic [15:0] flush;
    logic        tmo;
    logic [1:0]  stall2;
    logic [1:0]  flush2;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] idReadDir1, idReadDir2, exWriteDir;
  logic       idUsesRS1, idUsesRS2, exMemRead, exMulti, exDone;
  logic       memBranchTaken, memAccess, dmemReady;

  logic        pcEn, pcSelBranch, ifidEn, idexEn, exmemEn, memwbEn;
  logic        ifidFlush, idexFlush, exmemFlush, memwbFlush, exStart, memTimeout;
  logic [15:0] stallCount, flushCount;

  logic        pcEn2, pcSelBranch2, ifidEn2, idexEn2, exmemEn2, memwbEn2;
  logic        ifidFlush2, idexFlush2, exmemFlush2, memwbFlush2, exStart2, memTimeout2;
  logic [1:0]  stallCount2, flushCount2;

  exp_t  sb_q[$];
  string tag_q[$];
  int    n_assert = 0;
  int    n_fail   = 0;

  logic [15:0] m_stall = '0;
  logic [15:0] m_flush = '0;
  logic [1:0]  m_stall2 = '0;
  logic [1:0]  m_flush2 = '0;
  logic        m_tmo = 1'b0;

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(16), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .idReadDir1(idReadDir1), .idReadDir2(idReadDir2),
    .idUsesRS1(idUsesRS1), .idUsesRS2(idUsesRS2),
    .exWriteDir(exWriteDir), .exMemRead(exMemRead),
    .exMulti(exMulti), .exDone(exDone),
    .memBranchTaken(memBranchTaken), .memAccess(memAccess), .dmemReady(dmemReady),
    .pcEn(pcEn), .pcSelBranch(pcSelBranch),
    .ifidEn(ifidEn), .idexEn(idexEn), .exmemEn(exmemEn), .memwbEn(memwbEn),
    .ifidFlush(ifidFlush), .idexFlush(idexFlush), .exmemFlush(exmemFlush), .memwbFlush(memwbFlush),
    .exStart(exStart), .memTimeout(memTimeout),
    .stallCount(stallCount), .flushCount(flushCount)
  );

  // Narrow-counter instance on the same stimulus, for saturation.
  hazard_ctrl #(.CNT_W(2), .MEM_TIMEOUT(4)) dut_sat (
    .clk(clk), .rst(rst),
    .idReadDir1(idReadDir1), .idReadDir2(idReadDir2),
    .idUsesRS1(idUsesRS1), .idUsesRS2(idUsesRS2),
    .exWriteDir(exWriteDir), .exMemRead(exMemRead),
    .exMulti(exMulti), .exDone(exDone),
    .memBranchTaken(memBranchTaken), .memAccess(memAccess), .dmemReady(dmemReady),
    .pcEn(pcEn2), .pcSelBranch(pcSelBranch2),
    .ifidEn(ifidEn2), .idexEn(idexEn2), .exmemEn(exmemEn2), .memwbEn(memwbEn2),
    .ifidFlush(ifidFlush2), .idexFlush(idexFlush2), .exmemFlush(exmemFlush2), .memwbFlush(memwbFlush2),
    .exStart(exStart2), .memTimeout(memTimeout2),
    .stallCount(stallCount2), .flushCount(flushCount2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      exp_t  e;
      string t;
      e = sb_q.pop_front();
      t = tag_q.pop_front();
      check({t, "/ctrl"},  32'({pcEn, pcSelBranch, ifidEn, idexEn, exmemEn, memwbEn,
                                ifidFlush, idexFlush, exmemFlush, memwbFlush, exStart}), 32'(e.outs));
      check({t, "/stall"}, 32'(stallCount), 32'(e.stall));
      check({t, "/flush"}, 32'(flushCount), 32'(e.flush));
      check({t, "/tmo"},   32'(memTimeout), 32'(e.tmo));
      check({t, "/ctrl_sat"}, 32'({pcEn2, pcSelBranch2, ifidEn2, idexEn2, exmemEn2, memwbEn2,
                                   ifidFlush2, idexFlush2, exmemFlush2, memwbFlush2, exStart2}), 32'(e.outs));
      check({t, "/stall_sat"}, 32'(stallCount2), 32'(e.stall2));
      check({t, "/flush_sat"}, 32'(flushCount2), 32'(e.flush2));
      check({t, "/tmo_sat"},   32'(memTimeout2), 32'(e.tmo));
    end
  end

  // Queue the expectation for this cycle, then advance the counter model.
  task automatic step(input string tag, input logic [10:0] outs, input bit sets_tmo = 1'b0);
    exp_t e;
    e.outs   = outs;
    e.stall  = m_stall;
    e.flush  = m_flush;
    e.tmo    = m_tmo;
    e.stall2 = m_stall2;
    e.flush2 = m_flush2;
    sb_q.push_back(e);
    tag_q.push_back(tag);
    if (rst) begin
      m_stall = '0; m_flush = '0; m_stall2 = '0; m_flush2 = '0; m_tmo = 1'b0;
    end else begin
      if (!outs[10]) begin
        if (m_stall != 16'hFFFF) m_stall = m_stall + 1'b1;
        if (m_stall2 != 2'b11)   m_stall2 = m_stall2 + 1'b1;
      end
      if (outs[9]) begin
        if (m_flush != 16'hFFFF) m_flush = m_flush + 1'b1;
        if (m_flush2 != 2'b11)   m_flush2 = m_flush2 + 1'b1;
      end
      if (sets_tmo) m_tmo = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    idReadDir1 = '0; idReadDir2 = '0; exWriteDir = '0;
    idUsesRS1 = 1'b0; idUsesRS2 = 1'b0; exMemRead = 1'b0;
    exMulti = 1'b0; exDone = 1'b0;
    memBranchTaken = 1'b0; memAccess = 1'b0; dmemReady = 1'b1;
  endtask

  initial begin
    clr();
    rst = 1'b1;
    @(posedge clk);
    #1;
    step("reset", P_OFF);
    rst = 1'b0;
    step("idle", P_RUN);

    exMemRead = 1'b1; exWriteDir = 5'd5; idReadDir1 = 5'd5; idUsesRS1 = 1'b1;
    step("lu_rs1", P_LU);
    clr();
    step("lu_done", P_RUN);
    exMemRead = 1'b1; exWriteDir = 5'd0; idReadDir1 = 5'd0; idUsesRS1 = 1'b1;
    step("lu_x0", P_RUN);
    exWriteDir = 5'd7; idReadDir2 = 5'd7; idUsesRS2 = 1'b1; idReadDir1 = 5'd3;
    step("lu_rs2", P_LU);
    idUsesRS2 = 1'b0;
    step("lu_rs2_unused", P_RUN);
    clr(); exWriteDir = 5'd9; idReadDir1 = 5'd9; idUsesRS1 = 1'b1;
    step("no_load", P_RUN);

    clr(); memBranchTaken = 1'b1; exMulti = 1'b1;
    exMemRead = 1'b1; exWriteDir = 5'd5; idReadDir1 = 5'd5; idUsesRS1 = 1'b1;
    step("br_multi", P_BR);
    clr();
    step("br_done", P_RUN);

    exMulti = 1'b1;
    step("mc_start", P_MC);
    repeat (4) step("mc_wait", P_FRZ);
    exDone = 1'b1;
    step("mc_capture", P_RUN);
    clr();
    step("mc_done", P_RUN);

    memAccess = 1'b1; dmemReady = 1'b0;
    repeat (3) step("mw", P_MW);
    dmemReady = 1'b1;
    step("mw_ready", P_RUN);
    clr();
    step("mw_done", P_RUN);

    exMulti = 1'b1;
    step("mcw_start", P_MC);
    step("mcw_wait", P_FRZ);
    memAccess = 1'b1; dmemReady = 1'b0;
    step("mcw_mem", P_MW);
    step("mcw_mem2", P_MW);
    dmemReady = 1'b1; exDone = 1'b1;
    step("mcw_capture", P_RUN);
    clr();
    step("mcw_done", P_RUN);

    memAccess = 1'b1; dmemReady = 1'b0;
    repeat (3) step("to_wait", P_MW);
    step("to_last", P_MW, 1'b1);
    memBranchTaken = 1'b1;
    step("halt", P_OFF);
    dmemReady = 1'b1;
    step("halt2", P_OFF);
    rst = 1'b1;
    step("rst_halt", P_OFF);
    rst = 1'b0; clr();
    step("post_rst_halt", P_RUN);

    exMulti = 1'b1;
    step("rx_start", P_MC);
    step("rx_wait", P_FRZ);
    rst = 1'b1;
    step("rst_exwait", P_OFF);
    rst = 1'b0; clr();
    step("post_rst_exwait", P_RUN);

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
